// File: rtl/id_pkg.sv
// Shared definitions for the decode-stage operand fetch: instruction field
// positions, the bypass-source selector and the hard-wired zero register.
package id_pkg;

  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand source select (EX > MEM > WB > RF) and hazard detection.
// Full forwarding only when ID_BYPASS_EN is defined; otherwise any match stalls.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [4:0]        src,
  input  logic              use_op,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_valid,
  input  logic [4:0]        ex_dest,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ex_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  input  logic              wb_valid,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op,
  output logic              hazard
);

  logic     nonzero;
  fwd_sel_t sel;

  always_comb begin
    nonzero = (src != REG_ZERO);
    sel     = FWD_RF;
    if (nonzero && ex_valid && (ex_dest == src))
      sel = FWD_EX;
    else if (nonzero && mem_valid && (mem_dest == src))
      sel = FWD_MEM;
    else if (nonzero && wb_valid && (wb_dest == src))
      sel = FWD_WB;
  end

`ifdef ID_BYPASS_EN
  always_comb begin
    op     = rf_data;
    hazard = 1'b0;
    case (sel)
      FWD_EX: begin
        op     = ex_data;
        hazard = use_op && !ex_ready;
      end
      FWD_MEM: begin
        op     = mem_data;
        hazard = use_op && !mem_ready;
      end
      FWD_WB:  op = wb_data;
      default: op = rf_data;
    endcase
    if (!nonzero)
      op = '0;
  end
`else
  always_comb begin
    op     = nonzero ? rf_data : '0;
    hazard = use_op && (sel != FWD_RF);
  end

  logic unused_bypass;
  assign unused_bypass = ^{ex_data, ex_ready, mem_data, mem_ready, wb_data};
`endif

endmodule

// File: rtl/id_operand_fetch.sv
// Decode operand fetch with bypass resolution and ID/EX valid/ready latch.
// Forwarding muxes present only when ID_BYPASS_EN is defined.
module id_operand_fetch
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       InInstr,
  input  logic [31:0]       InPC,
  input  logic              InUseA,
  input  logic              InUseB,
  input  logic              InUseC,
  input  logic              InWrites,
  input  logic              InIsLoad,
  input  logic [4:0]        InDest,
  input  logic              InZeroExt,
  output logic [4:0]        RegA1,
  output logic [4:0]        RegB1,
  output logic [4:0]        RegC1,
  input  logic [DATA_W-1:0] DataA1,
  input  logic [DATA_W-1:0] DataB1,
  input  logic [DATA_W-1:0] DataC1,
  input  logic [DATA_W-1:0] ExResult,
  input  logic              ExResultValid,
  input  logic              MemValid,
  input  logic              MemWrites,
  input  logic              MemDataValid,
  input  logic [4:0]        MemDest,
  input  logic [DATA_W-1:0] MemData,
  input  logic              Write1,
  input  logic [4:0]        WriteReg1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutOpA,
  output logic [DATA_W-1:0] OutOpB,
  output logic [DATA_W-1:0] OutOpC,
  output logic [DATA_W-1:0] OutImm,
  output logic [31:0]       OutPC,
  output logic [4:0]        OutDest,
  output logic              OutWrites,
  output logic              OutIsLoad,
  output logic [CNT_W-1:0]  StallCount
);

  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_a, op_b, op_c;
  logic              haz_a, haz_b, haz_c, hazard, load;
  logic              ex_valid, mem_valid;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_op_a_q, out_op_a_d;
  logic [DATA_W-1:0] out_op_b_q, out_op_b_d;
  logic [DATA_W-1:0] out_op_c_q, out_op_c_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [4:0]        out_dest_q, out_dest_d;
  logic              out_writes_q, out_writes_d;
  logic              out_is_load_q, out_is_load_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign RegA1     = InInstr[RS_MSB:RS_LSB];
  assign RegB1     = InInstr[RT_MSB:RT_LSB];
  assign RegC1     = InInstr[RD_MSB:RD_LSB];
  assign imm       = InInstr[IMM_MSB:IMM_LSB];
  assign imm_ext   = InZeroExt ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};
  assign ex_valid  = out_valid_q && out_writes_q;
  assign mem_valid = MemValid && MemWrites;

  id_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .src(RegA1), .use_op(InUseA), .rf_data(DataA1),
    .ex_valid(ex_valid), .ex_dest(out_dest_q), .ex_data(ExResult), .ex_ready(ExResultValid),
    .mem_valid(mem_valid), .mem_dest(MemDest), .mem_data(MemData), .mem_ready(MemDataValid),
    .wb_valid(Write1), .wb_dest(WriteReg1), .wb_data(WriteData1),
    .op(op_a), .hazard(haz_a)
  );

  id_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .src(RegB1), .use_op(InUseB), .rf_data(DataB1),
    .ex_valid(ex_valid), .ex_dest(out_dest_q), .ex_data(ExResult), .ex_ready(ExResultValid),
    .mem_valid(mem_valid), .mem_dest(MemDest), .mem_data(MemData), .mem_ready(MemDataValid),
    .wb_valid(Write1), .wb_dest(WriteReg1), .wb_data(WriteData1),
    .op(op_b), .hazard(haz_b)
  );

  id_fwd_mux #(.DATA_W(DATA_W)) u_fwd_c (
    .src(RegC1), .use_op(InUseC), .rf_data(DataC1),
    .ex_valid(ex_valid), .ex_dest(out_dest_q), .ex_data(ExResult), .ex_ready(ExResultValid),
    .mem_valid(mem_valid), .mem_dest(MemDest), .mem_data(MemData), .mem_ready(MemDataValid),
    .wb_valid(Write1), .wb_dest(WriteReg1), .wb_data(WriteData1),
    .op(op_c), .hazard(haz_c)
  );

  always_comb begin
    hazard  = haz_a || haz_b || haz_c;
    InReady = Flush || (!hazard && (!out_valid_q || OutReady));
    load    = InValid && InReady && !Flush;

    out_valid_d   = out_valid_q;
    out_op_a_d    = out_op_a_q;
    out_op_b_d    = out_op_b_q;
    out_op_c_d    = out_op_c_q;
    out_imm_d     = out_imm_q;
    out_pc_d      = out_pc_q;
    out_dest_d    = out_dest_q;
    out_writes_d  = out_writes_q;
    out_is_load_d = out_is_load_q;

    // Flush beats load; a drained latch with no new load becomes a bubble.
    if (Flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d   = 1'b1;
      out_op_a_d    = op_a;
      out_op_b_d    = op_b;
      out_op_c_d    = op_c;
      out_imm_d     = imm_ext;
      out_pc_d      = InPC;
      out_dest_d    = InDest;
      out_writes_d  = InWrites;
      out_is_load_d = InIsLoad;
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (InValid && hazard && !Flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid_q   <= 1'b0;
      out_op_a_q    <= '0;
      out_op_b_q    <= '0;
      out_op_c_q    <= '0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
      out_dest_q    <= '0;
      out_writes_q  <= 1'b0;
      out_is_load_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_op_a_q    <= out_op_a_d;
      out_op_b_q    <= out_op_b_d;
      out_op_c_q    <= out_op_c_d;
      out_imm_q     <= out_imm_d;
      out_pc_q      <= out_pc_d;
      out_dest_q    <= out_dest_d;
      out_writes_q  <= out_writes_d;
      out_is_load_q <= out_is_load_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign OutValid   = out_valid_q;
  assign OutOpA     = out_op_a_q;
  assign OutOpB     = out_op_b_q;
  assign OutOpC     = out_op_c_q;
  assign OutImm     = out_imm_q;
  assign OutPC      = out_pc_q;
  assign OutDest    = out_dest_q;
  assign OutWrites  = out_writes_q;
  assign OutIsLoad  = out_is_load_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed scenarios plus a randomized program checked against an
// architectural register model (operand = value of the last older writer).
module tb_id_operand_fetch;

  localparam int unsigned CW     = 4;
  localparam int unsigned N_RAND = 300;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        InValid, InReady;
  logic [31:0] InInstr, InPC;
  logic        InUseA, InUseB, InUseC, InWrites, InIsLoad, InZeroExt;
  logic [4:0]  InDest, RegA1, RegB1, RegC1;
  logic [31:0] DataA1, DataB1, DataC1, ExResult, MemData, WriteData1;
  logic        ExResultValid, MemValid, MemWrites, MemDataValid, Write1, Flush;
  logic [4:0]  MemDest, WriteReg1;
  logic        OutValid, OutReady, OutWrites, OutIsLoad;
  logic [31:0] OutOpA, OutOpB, OutOpC, OutImm, OutPC;
  logic [4:0]  OutDest;
  logic [CW-1:0] StallCount;

  id_operand_fetch #(.DATA_W(32), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .InValid(InValid), .InReady(InReady), .InInstr(InInstr), .InPC(InPC),
    .InUseA(InUseA), .InUseB(InUseB), .InUseC(InUseC),
    .InWrites(InWrites), .InIsLoad(InIsLoad), .InDest(InDest), .InZeroExt(InZeroExt),
    .RegA1(RegA1), .RegB1(RegB1), .RegC1(RegC1),
    .DataA1(DataA1), .DataB1(DataB1), .DataC1(DataC1),
    .ExResult(ExResult), .ExResultValid(ExResultValid),
    .MemValid(MemValid), .MemWrites(MemWrites), .MemDataValid(MemDataValid),
    .MemDest(MemDest), .MemData(MemData),
    .Write1(Write1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutOpA(OutOpA), .OutOpB(OutOpB), .OutOpC(OutOpC), .OutImm(OutImm), .OutPC(OutPC),
    .OutDest(OutDest), .OutWrites(OutWrites), .OutIsLoad(OutIsLoad),
    .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, imm, opa, opb, opc, res;
    logic        usea, useb, usec, writes, isload;
    logic [4:0]  dest;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_stall = 0;
  int          issued;
  ent_t        expq[$];
  ent_t        cur, mem_st, wb_st, e;
  logic        cur_v, mem_v, wb_v, mem_dv, out_fire, in_acc, c_zext;
  logic [4:0]  c_rs, c_rt, c_rd;
  logic [10:0] c_lo;
  logic [5:0]  c_top;
  logic [15:0] c_imm;
  logic [31:0] rf[32];
  logic [31:0] arch[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int sat_inc(input int v, input int n);
    int m = (1 << CW) - 1;
    return (v + n > m) ? m : v + n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_env();
    InValid = 1'b0; InInstr = '0; InPC = '0;
    InUseA = 1'b0; InUseB = 1'b0; InUseC = 1'b0;
    InWrites = 1'b0; InIsLoad = 1'b0; InDest = '0; InZeroExt = 1'b0;
    DataA1 = '0; DataB1 = '0; DataC1 = '0;
    ExResult = '0; ExResultValid = 1'b0;
    MemValid = 1'b0; MemWrites = 1'b0; MemDataValid = 1'b0; MemDest = '0; MemData = '0;
    Write1 = 1'b0; WriteReg1 = '0; WriteData1 = '0;
    Flush = 1'b0; OutReady = 1'b1;
  endtask

  task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [10:0] lo, input logic [31:0] pc,
                         input logic ua, input logic ub, input logic uc,
                         input logic wr, input logic ld, input logic [4:0] dest);
    InValid = 1'b1; InInstr = {6'h08, rs, rt, rd, lo}; InPC = pc;
    InUseA = ua; InUseB = ub; InUseC = uc;
    InWrites = wr; InIsLoad = ld; InDest = dest;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_env();
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #1;
    chk("rst_valid", OutValid, 0);
    chk("rst_opa", OutOpA, 0);
    chk("rst_imm", OutImm, 0);
    chk("rst_dest", OutDest, 0);
    chk("rst_wr_ld", {OutWrites, OutIsLoad}, 0);
    chk("rst_stall", StallCount, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
    tick();

    // Independent add, sign-extended negative immediate, producer of r8
    present(5'd3, 5'd4, 5'h10, 11'h123, 32'h100, 1, 1, 0, 1, 0, 5'd8);
    DataA1 = 32'd5; DataB1 = 32'd7;
    #1;
    chk("rega", RegA1, 3);
    chk("regb", RegB1, 4);
    chk("regc", RegC1, 5'h10);
    chk("add_inready", InReady, 1);
    tick();
    chk("add_valid", OutValid, 1);
    chk("add_opa", OutOpA, 5);
    chk("add_opb", OutOpB, 7);
    chk("add_imm", OutImm, 32'hFFFF_8123);
    chk("add_pc", OutPC, 32'h100);
    chk("add_dest", OutDest, 8);
    chk("add_stall", StallCount, 0);

    // Consumer of r8 while producer is in the output latch, zero-extended 0xFFFF
    present(5'd8, 5'd0, 5'h1F, 11'h7FF, 32'h104, 1, 0, 0, 0, 0, 5'd0);
    InZeroExt = 1'b1; DataA1 = '0; DataB1 = '0;
    ExResult = 32'h1234; ExResultValid = 1'b1;
`ifdef ID_BYPASS_EN
    #1 chk("ex_inready", InReady, 1);
    tick();
`else
    #1 chk("ex_inready", InReady, 0);
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    chk("ex_bubble", OutValid, 0);
    ExResultValid = 1'b0;
    MemValid = 1'b1; MemWrites = 1'b1; MemDest = 5'd8; MemData = 32'h1234; MemDataValid = 1'b1;
    #1 chk("ex_mem_inready", InReady, 0);
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    MemValid = 1'b0;
    Write1 = 1'b1; WriteReg1 = 5'd8; WriteData1 = 32'h1234;
    #1 chk("ex_wb_inready", InReady, 0);
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    Write1 = 1'b0; DataA1 = 32'h1234;
    #1 chk("ex_rf_inready", InReady, 1);
    tick();
`endif
    chk("ex_opa", OutOpA, 32'h1234);
    chk("ex_imm", OutImm, 32'h0000_FFFF);
    chk("ex_stall", StallCount, exp_stall);

    // Load to r9 then a dependent consumer on rt
    idle_env();
    present(5'd9, 5'd9, 5'd0, 11'h0, 32'h108, 0, 0, 0, 1, 1, 5'd9);
    tick();
    chk("ld_isload", OutIsLoad, 1);
    chk("ld_dest", OutDest, 9);
    present(5'd0, 5'd9, 5'd0, 11'h4, 32'h10C, 0, 1, 0, 0, 0, 5'd0);
    ExResult = 32'hDEAD; ExResultValid = 1'b0;
    #1 chk("lu_inready", InReady, 0);
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    chk("lu_bubble", OutValid, 0);
    MemValid = 1'b1; MemWrites = 1'b1; MemDest = 5'd9; MemData = 32'hCAFE; MemDataValid = 1'b0;
    #1 chk("lu_memwait", InReady, 0);
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    MemDataValid = 1'b1;
`ifdef ID_BYPASS_EN
    #1 chk("lu_mem_inready", InReady, 1);
    tick();
`else
    #1 chk("lu_mem_inready", InReady, 0);
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    MemValid = 1'b0;
    Write1 = 1'b1; WriteReg1 = 5'd9; WriteData1 = 32'hCAFE;
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    Write1 = 1'b0; DataB1 = 32'hCAFE;
    tick();
`endif
    chk("lu_valid", OutValid, 1);
    chk("lu_opb", OutOpB, 32'hCAFE);
    chk("lu_stall", StallCount, exp_stall);

    // WB write of r2 while register file still returns the stale value
    idle_env();
    present(5'd2, 5'd0, 5'd0, 11'h0, 32'h110, 1, 0, 0, 0, 0, 5'd0);
    Write1 = 1'b1; WriteReg1 = 5'd2; WriteData1 = 32'h55; DataA1 = '0;
`ifdef ID_BYPASS_EN
    tick();
`else
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    Write1 = 1'b0; DataA1 = 32'h55;
    tick();
`endif
    chk("wb_opa", OutOpA, 32'h55);
    chk("wb_stall", StallCount, exp_stall);

    // Register 0: forced to zero and never matched by any bypass source
    present(5'd0, 5'd0, 5'd0, 11'h0, 32'h114, 1, 1, 0, 1, 0, 5'd0);
    DataA1 = 32'hFFFF_FFFF; DataB1 = 32'hFFFF_FFFF;
    Write1 = 1'b1; WriteReg1 = 5'd0; WriteData1 = 32'h77;
    MemValid = 1'b1; MemWrites = 1'b1; MemDest = 5'd0; MemDataValid = 1'b0;
    #1 chk("r0_inready", InReady, 1);
    tick();
    chk("r0_opa", OutOpA, 0);
    chk("r0_opb", OutOpB, 0);
    chk("r0_stall", StallCount, exp_stall);

    // Downstream back-pressure, then flush
    idle_env();
    present(5'd1, 5'd0, 5'd0, 11'h0, 32'h118, 1, 0, 0, 0, 0, 5'd0);
    DataA1 = 32'h11; OutReady = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 chk("hold_inready", InReady, 0);
      tick();
      chk("hold_valid", OutValid, 1);
      chk("hold_pc", OutPC, 32'h114);
    end
    chk("hold_stall", StallCount, exp_stall);
    Flush = 1'b1;
    #1 chk("flush_inready", InReady, 1);
    tick();
    chk("flush_valid", OutValid, 0);

    // Flush together with a hazard: no stall counted
    present(5'd5, 5'd0, 5'd0, 11'h0, 32'h11C, 1, 0, 0, 0, 0, 5'd0);
    OutReady = 1'b1;
    MemValid = 1'b1; MemWrites = 1'b1; MemDest = 5'd5; MemDataValid = 1'b0;
    tick();
    chk("fh_valid", OutValid, 0);
    chk("fh_stall", StallCount, exp_stall);
    Flush = 1'b0;
    tick();
    exp_stall = sat_inc(exp_stall, 1);
    chk("haz_stall", StallCount, exp_stall);
    chk("haz_valid", OutValid, 0);
    InUseA = 1'b0;
    `ifdef ID_BYPASS_EN `endif
    #1 chk("unused_inready", InReady, 1);
    tick();
    chk("unused_valid", OutValid, 1);
    chk("unused_pc", OutPC, 32'h11C);

    // Long stall to saturation, then asynchronous reset mid-stall
    InUseA = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      exp_stall = sat_inc(exp_stall, 1);
    end
    chk("sat_stall", StallCount, exp_stall);
    chk("sat_inready", InReady, 0);
    #2 RESET = 1'b0;
    #1;
    chk("rst2_valid", OutValid, 0);
    chk("rst2_stall", StallCount, 0);
    chk("rst2_pc", OutPC, 0);
    idle_env();
    @(negedge CLK) RESET = 1'b1;
    tick();

    // Randomized program against architectural register model
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      arch[i] = '0;
    end
    mem_st = '{default: '0};
    wb_st = '{default: '0};
    cur = '{default: '0};
    mem_v = 1'b0; wb_v = 1'b0; mem_dv = 1'b0; cur_v = 1'b0; issued = 0;
    c_rs = '0; c_rt = '0; c_rd = '0; c_lo = '0; c_top = '0; c_zext = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (issued == N_RAND && expq.size() == 0 && !cur_v) break;
      if (!cur_v && issued < N_RAND && $urandom_range(3, 0) != 0) begin
        c_rs = 5'($urandom_range(7, 0));
        c_rt = 5'($urandom_range(7, 0));
        c_rd = 5'($urandom_range(7, 0));
        c_lo = 11'($urandom);
        c_top = 6'($urandom);
        c_zext = 1'($urandom_range(1, 0));
        c_imm = {c_rd, c_lo};
        cur = '{default: '0};
        cur.pc = 32'h1000 + 32'(issued) * 4;
        cur.res = res_of(cur.pc);
        cur.imm = c_zext ? {16'h0, c_imm} : {{16{c_imm[15]}}, c_imm};
        cur.usea = 1'($urandom_range(1, 0));
        cur.useb = 1'($urandom_range(1, 0));
        cur.usec = ($urandom_range(3, 0) == 0);
        cur.writes = ($urandom_range(3, 0) != 0);
        cur.isload = cur.writes && ($urandom_range(3, 0) == 0);
        cur.dest = 5'($urandom_range(7, 0));
        cur_v = 1'b1;
        issued++;
      end
      InValid = cur_v;
      InInstr = {c_top, c_rs, c_rt, c_rd, c_lo};
      InPC = cur.pc; InZeroExt = c_zext;
      InUseA = cur.usea; InUseB = cur.useb; InUseC = cur.usec;
      InWrites = cur.writes; InIsLoad = cur.isload; InDest = cur.dest;
      DataA1 = (c_rs == 0) ? $urandom : rf[c_rs];
      DataB1 = (c_rt == 0) ? $urandom : rf[c_rt];
      DataC1 = (c_rd == 0) ? $urandom : rf[c_rd];
      OutReady = ($urandom_range(3, 0) != 0);
      if (expq.size() != 0) begin
        ExResult = expq[0].res;
        ExResultValid = !expq[0].isload;
      end else begin
        ExResult = $urandom;
        ExResultValid = 1'($urandom_range(1, 0));
      end
      MemValid = mem_v; MemWrites = mem_st.writes; MemDest = mem_st.dest;
      MemData = mem_st.res; MemDataValid = mem_dv;
      Write1 = wb_v && wb_st.writes; WriteReg1 = wb_st.dest; WriteData1 = wb_st.res;

      @(negedge CLK);
      chk("r_rega", RegA1, c_rs);
      chk("r_regc", RegC1, c_rd);
      chk("r_valid", OutValid, (expq.size() != 0));
      out_fire = OutValid && OutReady;
      in_acc = InValid && InReady;

      if (wb_v && wb_st.writes && wb_st.dest != 0) rf[wb_st.dest] = wb_st.res;
      wb_v = mem_v; wb_st = mem_st;
      mem_v = 1'b0; mem_dv = 1'b0;
      if (out_fire && expq.size() != 0) begin
        e = expq.pop_front();
        chk("r_pc", OutPC, e.pc);
        chk("r_imm", OutImm, e.imm);
        chk("r_dest", OutDest, e.dest);
        chk("r_wr_ld", {OutWrites, OutIsLoad}, {e.writes, e.isload});
        if (e.usea) chk("r_opa", OutOpA, e.opa);
        if (e.useb) chk("r_opb", OutOpB, e.opb);
        if (e.usec) chk("r_opc", OutOpC, e.opc);
        mem_v = 1'b1; mem_st = e;
        mem_dv = e.isload ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      if (in_acc) begin
        e = cur;
        e.opa = arch[c_rs];
        e.opb = arch[c_rt];
        e.opc = arch[c_rd];
        expq.push_back(e);
        if (e.writes && e.dest != 0) arch[e.dest] = e.res;
        cur_v = 1'b0;
      end
      @(posedge CLK);
      #1;
    end
    chk("r_drain", {31'b0, (issued == N_RAND && expq.size() == 0 && !cur_v)}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
